// File: rtl/register_pkg.sv
// Shared definitions for the universal register: the 3-bit operation select.
package register_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_INC  = 3'd6,
        MODE_DEC  = 3'd7
    } mode_t;

endpackage

// File: rtl/register_universal_nxt.sv
// Combinational next-state for the universal register: computes the value and
// carry/shift-out that the selected mode would produce from the current contents.
module register_universal_nxt
    import register_pkg::*;
#(
    parameter int N = 4
) (
    input  mode_t          mode,
    input  logic [N-1:0]   qout,
    input  logic [N-1:0]   din,
    input  logic           ser_in,
    output logic [N-1:0]   nxt_q,
    output logic           nxt_co
);

    logic [N-1:0] shl_q;
    logic [N-1:0] shr_q;
    logic [N-1:0] rol_q;
    logic [N-1:0] ror_q;

    // A 1-bit register has no bits to move: shifts take ser_in, rotates keep the bit.
    generate
        if (N == 1) begin : g_single
            assign shl_q = ser_in;
            assign shr_q = ser_in;
            assign rol_q = qout;
            assign ror_q = qout;
        end else begin : g_wide
            assign shl_q = {qout[N-2:0], ser_in};
            assign shr_q = {ser_in, qout[N-1:1]};
            assign rol_q = {qout[N-2:0], qout[N-1]};
            assign ror_q = {qout[0], qout[N-1:1]};
        end
    endgenerate

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        nxt_q  = qout;
        nxt_co = 1'b0;
        case (mode)
            MODE_HOLD: nxt_q = qout;
            MODE_LOAD: nxt_q = din;
            MODE_SHL: begin
                nxt_q  = shl_q;
                nxt_co = qout[N-1];
            end
            MODE_SHR: begin
                nxt_q  = shr_q;
                nxt_co = qout[0];
            end
            MODE_ROL: begin
                nxt_q  = rol_q;
                nxt_co = qout[N-1];
            end
            MODE_ROR: begin
                nxt_q  = ror_q;
                nxt_co = qout[0];
            end
            MODE_INC: begin
                nxt_q  = qout + N'(1);
                nxt_co = &qout;
            end
            MODE_DEC: begin
                nxt_q  = qout - N'(1);
                nxt_co = ~|qout;
            end
        endcase
    end

endmodule

// File: rtl/register_universal.sv
// N-bit universal register: async reset to RST_VAL, sync clear, clock enable,
// and eight modes (hold/load/shift/rotate/inc/dec) with registered carry and zero flag.
module register_universal
    import register_pkg::*;
#(
    parameter int             N       = 4,
    parameter logic [N-1:0]   RST_VAL = '0
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clr,
    input  logic           en,
    input  mode_t          mode,
    input  logic [N-1:0]   din,
    input  logic           ser_in,
    output logic [N-1:0]   qout,
    output logic           co,
    output logic           zero
);

    logic [N-1:0] nxt_q;
    logic         nxt_co;

    register_universal_nxt #(.N(N)) u_nxt (
        .mode   (mode),
        .qout   (qout),
        .din    (din),
        .ser_in (ser_in),
        .nxt_q  (nxt_q),
        .nxt_co (nxt_co)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state flops use non-blocking assignments so all registers sample pre-edge values.
        if (!reset_n) begin
            qout <= RST_VAL;
            co   <= 1'b0;
        end else if (clr) begin
            qout <= RST_VAL;
            co   <= 1'b0;
        end else if (en) begin
            qout <= nxt_q;
            // HOLD is the only mode that leaves the carry untouched.
            if (mode != MODE_HOLD) begin
                co <= nxt_co;
            end
        end
    end

    assign zero = (qout == '0);

endmodule
